// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// Memory stage of the pipeline. It turns the ALU result into an SRAM word
// address, runs a request/acknowledge access to an external data SRAM for
// loads and stores, stalls the earlier stages via freeze while the access is
// outstanding, and registers the MEM/WB values for the write-back stage.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   wb_en_in        write-back enable from EX/MEM
//   mem_read        load request
//   mem_write       store request (wins when both requests are high)
//   alu_out         ALU result, also the byte address of the access
//   val_rm          store data
//   dest_in         destination register
//   sram_addr       word address to SRAM, (alu_out - BASE_ADDR) >> 2
//   sram_wdata      store data to SRAM
//   sram_we/re      write / read strobes, held until ack or timeout
//   sram_ack        one-cycle completion pulse from SRAM
//   sram_rdata      load data, valid in the sram_ack cycle
//   freeze          stall request to all earlier pipeline registers
//   mem_err         sticky flag, set when an access times out
//   wb_en_out, mem_r_en_out, alu_result_out, mem_data_out, dest_out
//                   registered MEM/WB values
module mem_access_stage #(
    parameter int BASE_ADDR = 1024,
    parameter int ADDR_W    = 16,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       val_rm,
    input  logic [3:0]        dest_in,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_we,
    output logic              sram_re,
    input  logic              sram_ack,
    input  logic [31:0]       sram_rdata,
    output logic              freeze,
    output logic              mem_err,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [31:0]       alu_result_out,
    output logic [31:0]       mem_data_out,
    output logic [3:0]        dest_out
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               is_write_reg, is_write_next;
    logic               mem_err_reg;
    logic               set_err;

    logic               wb_en_reg, wb_en_next;
    logic               mem_r_en_reg, mem_r_en_next;
    logic [31:0]        alu_result_reg, alu_result_next;
    logic [31:0]        mem_data_reg, mem_data_next;
    logic [3:0]         dest_reg, dest_next;

    logic               req;
    logic               timed_out;

    // Address and data are purely combinational; upstream registers are
    // frozen during WAIT, so they stay stable for the whole access.
    assign sram_addr  = ADDR_W'((alu_out - 32'(BASE_ADDR)) >> 2);
    assign sram_wdata = val_rm;

    assign req       = mem_read | mem_write;
    assign timed_out = (cnt_reg == CNT_W'(TIMEOUT));

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        is_write_next   = is_write_reg;
        set_err         = 1'b0;
        sram_we         = 1'b0;
        sram_re         = 1'b0;
        freeze          = 1'b0;
        wb_en_next      = wb_en_reg;
        mem_r_en_next   = mem_r_en_reg;
        alu_result_next = alu_result_reg;
        mem_data_next   = mem_data_reg;
        dest_next       = dest_reg;

        case (state_reg)
            IDLE: begin
                alu_result_next = alu_out;
                dest_next       = dest_in;
                mem_data_next   = 32'd0;
                if (req) begin
                    // Issue: strobe now, stall, and send a bubble to WB
                    // until the access resolves.
                    sram_we       = mem_write;
                    sram_re       = mem_read & ~mem_write;
                    freeze        = 1'b1;
                    cnt_next      = '0;
                    is_write_next = mem_write;
                    state_next    = WAIT;
                    wb_en_next    = 1'b0;
                    mem_r_en_next = 1'b0;
                end else begin
                    wb_en_next    = wb_en_in;
                    mem_r_en_next = 1'b0;
                end
            end
            WAIT: begin
                sram_we  = is_write_reg;
                sram_re  = ~is_write_reg;
                cnt_next = cnt_reg + CNT_W'(1);
                if (sram_ack) begin
                    // Release the stall in the ack cycle itself so the next
                    // instruction can issue right after.
                    state_next      = IDLE;
                    wb_en_next      = wb_en_in;
                    mem_r_en_next   = ~is_write_reg;
                    alu_result_next = alu_out;
                    dest_next       = dest_in;
                    mem_data_next   = is_write_reg ? 32'd0 : sram_rdata;
                end else if (timed_out) begin
                    // Abort: a failed load must never reach the register file.
                    state_next      = IDLE;
                    set_err         = 1'b1;
                    wb_en_next      = 1'b0;
                    mem_r_en_next   = ~is_write_reg;
                    alu_result_next = alu_out;
                    dest_next       = dest_in;
                    mem_data_next   = 32'd0;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Reset kills the access immediately, not one cycle later.
        if (rst) begin
            sram_we = 1'b0;
            sram_re = 1'b0;
            freeze  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            is_write_reg   <= 1'b0;
            mem_err_reg    <= 1'b0;
            wb_en_reg      <= 1'b0;
            mem_r_en_reg   <= 1'b0;
            alu_result_reg <= 32'd0;
            mem_data_reg   <= 32'd0;
            dest_reg       <= 4'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            is_write_reg   <= is_write_next;
            mem_err_reg    <= mem_err_reg | set_err;
            wb_en_reg      <= wb_en_next;
            mem_r_en_reg   <= mem_r_en_next;
            alu_result_reg <= alu_result_next;
            mem_data_reg   <= mem_data_next;
            dest_reg       <= dest_next;
        end
    end

    assign mem_err        = mem_err_reg;
    assign wb_en_out      = wb_en_reg;
    assign mem_r_en_out   = mem_r_en_reg;
    assign alu_result_out = alu_result_reg;
    assign mem_data_out   = mem_data_reg;
    assign dest_out       = dest_reg;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage that sits directly downstream of the execute stage and responds to its load/store requests.
- Takes the ALU result as a byte address and Val_Rm as store data, and runs a handshaked access to an external data SRAM.
- Raises a pipeline freeze until the access completes.
- Registers the MEM/WB pipeline values (result, load data, destination, write-back enable) for the write-back stage.

Parameters:
- BASE_ADDR, 1024, byte offset subtracted from ALU_out before word addressing.
- ADDR_W, 16, width of the SRAM word address.
- TIMEOUT, 15, maximum wait cycles for sram_ack before the access is aborted.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- wb_en_in  in  1  write-back enable from EX/MEM.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- alu_out  in  32  ALU result / byte address.
- val_rm  in  32  store data.
- dest_in  in  4  destination register.
- sram_addr  out  ADDR_W  word address to SRAM.
- sram_wdata  out  32  store data to SRAM.
- sram_we  out  1  write strobe.
- sram_re  out  1  read strobe.
- sram_ack  in  1  one-cycle completion pulse from SRAM.
- sram_rdata  in  32  load data, valid in the sram_ack cycle.
- freeze  out  1  stall request to all earlier pipeline registers.
- mem_err  out  1  sticky timeout flag.
- wb_en_out  out  1  registered write-back enable.
- mem_r_en_out  out  1  registered load indicator (WB mux select).
- alu_result_out  out  32  registered ALU result.
- mem_data_out  out  32  registered load data.
- dest_out  out  4  registered destination.

Behaviour:
- Synchronous active-high reset, one clock domain. Clock port is clk, reset port is rst.
- Reset values:
  - state is IDLE.
  - All registered outputs are 0.
  - mem_err is 0.
  - Wait counter is 0.
  - sram_we and sram_re are 0.
- sram_addr = (alu_out - BASE_ADDR) >> 2, truncated to ADDR_W bits; sram_wdata = val_rm. Both are combinational and held stable while in WAIT, because freeze holds the upstream inputs.
- Request rule: req = mem_read | mem_write. If both are high, the write wins: sram_we = 1, sram_re = 0.
- FSM states IDLE, WAIT.
  - IDLE, req = 0: freeze = 0. The MEM/WB registers load the inputs and mem_data_out = 0.
  - IDLE, req = 1: drive the strobe (sram_we = mem_write, sram_re = mem_read & ~mem_write), set freeze = 1, clear the counter, go to WAIT.
    - The MEM/WB registers load a bubble: wb_en_out = 0, mem_r_en_out = 0.
  - WAIT: keep the strobe asserted and increment the counter each cycle.
    - If sram_ack = 1: freeze = 0 combinationally in that cycle. The MEM/WB registers load the inputs, and mem_data_out = sram_rdata when the access is a load. Next state is IDLE.
    - If sram_ack = 0 and counter == TIMEOUT: abort. freeze = 0, mem_err is set, the MEM/WB registers load the inputs with wb_en_out forced to 0 (a failed load must not write back), mem_data_out = 0. Next state is IDLE.
- Latency:
  - Non-memory instruction: 0 stall cycles.
  - Memory access: 1 + k stall-free cycles after issue, where k is the cycle index of sram_ack (ack one cycle after issue means freeze is high for exactly 1 cycle).
- Back-to-back accesses: after returning to IDLE with a new req present, issue immediately in the same cycle. There is no idle gap.
- sram_ack received in IDLE is ignored.
- mem_err clears only on rst.
- Reset during WAIT aborts the access: strobes drop the same cycle rst is sampled, and state returns to IDLE.

Test Plan:
- Reset: hold rst for 2 cycles -> all outputs 0, freeze = 0, state IDLE.
- ALU-only op: alu_out = 0x0000_0055, wb_en_in = 1, dest_in = 3 -> next cycle alu_result_out = 0x55, wb_en_out = 1, dest_out = 3, freeze never high.
- Load: mem_read = 1, alu_out = 1028, ack 2 cycles after issue with sram_rdata = 0xDEAD_BEEF -> sram_addr = 1, sram_re = 1, freeze high for 2 cycles, then mem_data_out = 0xDEADBEEF, mem_r_en_out = 1.
- Store: mem_write = 1, alu_out = 1032, val_rm = 0x1234 -> sram_addr = 2, sram_wdata = 0x1234, sram_we = 1 until ack, then wb_en_out follows wb_en_in.
- Timeout: load with no ack -> freeze high TIMEOUT+1 cycles, then mem_err = 1, wb_en_out = 0, FSM back in IDLE.
- Simultaneous read and write, plus mid-access reset: mem_read = mem_write = 1 -> sram_we = 1, sram_re = 0. Assert rst in WAIT -> strobes 0 the same cycle, outputs return to reset values.
